// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, cycles-per-bit and parity helpers.
// Used by uart_tx and uart_rx so both ends agree on framing.
package uart_pkg;

    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_START_ENC  = 3'd1;
    localparam logic [2:0] ST_DATA_ENC   = 3'd2;
    localparam logic [2:0] ST_PARITY_ENC = 3'd3;
    localparam logic [2:0] ST_STOP_ENC   = 3'd4;
    localparam logic [2:0] ST_ERROR_ENC  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_START  = ST_START_ENC,
        ST_DATA   = ST_DATA_ENC,
        ST_PARITY = ST_PARITY_ENC,
        ST_STOP   = ST_STOP_ENC,
        ST_ERROR  = ST_ERROR_ENC
    } uart_state_e;

    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                   input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // sel=1 yields the XOR of the byte, sel=0 its complement; uart_rx checks the same value.
    function automatic logic parity_bit(input logic sel, input logic [7:0] data);
        return sel ? (^data) : (~^data);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period cycle counter: counts 0..p_cycles_per_bit-1 while running,
// pulses tc_o on the last cycle of each bit and wraps to zero.
module uart_baud_cnt #(
    parameter int unsigned p_cycles_per_bit = 10
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic run_i,
    output logic tc_o
);

    localparam int unsigned CW = $clog2(p_cycles_per_bit) + 1;
    localparam logic [CW-1:0] TC = CW'(p_cycles_per_bit - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (run_i) begin
            cnt_q <= (cnt_q == TC) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tc_o = run_i && (cnt_q == TC);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned p_clk_speed_hz = 50_000_000,
    parameter int unsigned p_baud_rate    = 9_600
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    input  logic       parity_en_i,
    input  logic       parity_sel_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(p_clk_speed_hz, p_baud_rate);

    generate
        if (CYCLES_PER_BIT < 2) begin : g_cpb_check
            $error("uart_tx: CYCLES_PER_BIT must be at least 2");
        end
    endgenerate

    uart_state_e state_q;
    logic [7:0]  data_q;
    logic        par_en_q;
    logic        par_sel_q;
    logic [2:0]  bit_cnt_q;
    logic        tx_q;
    logic        done_q;
    logic        bit_tc;
    logic        accept;
`ifdef UART_TX_TWO_STOP_EN
    logic        stop_cnt_q;
`endif

    assign data_ready_o = rst_n_i && enable_i && (state_q == ST_IDLE);
    assign accept       = data_valid_i && data_ready_o;

    // Counter is held at zero in IDLE so the start bit gets a full period from the accept edge.
    uart_baud_cnt #(
        .p_cycles_per_bit(CYCLES_PER_BIT)
    ) u_baud_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (state_q == ST_IDLE),
        .run_i   (state_q != ST_IDLE),
        .tc_o    (bit_tc)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_sel_q <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q      <= 1'b1;
                    bit_cnt_q <= '0;
`ifdef UART_TX_TWO_STOP_EN
                    stop_cnt_q <= 1'b0;
`endif
                    if (accept) begin
                        data_q    <= data_i;
                        par_en_q  <= parity_en_i;
                        par_sel_q <= parity_sel_i;
                        tx_q      <= 1'b0;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tc) begin
                        state_q   <= ST_DATA;
                        tx_q      <= data_q[0];
                        bit_cnt_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_tc) begin
                        if (bit_cnt_q == 3'd7) begin
                            if (par_en_q) begin
                                state_q <= ST_PARITY;
                                tx_q    <= parity_bit(par_sel_q, data_q);
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            tx_q      <= data_q[bit_cnt_q + 3'd1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tc) begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    tx_q <= 1'b1;
                    if (bit_tc) begin
`ifdef UART_TX_TWO_STOP_EN
                        if (!stop_cnt_q) begin
                            stop_cnt_q <= 1'b1;
                        end else begin
                            stop_cnt_q <= 1'b0;
                            state_q    <= ST_IDLE;
                            done_q     <= 1'b1;
                        end
`else
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx at 10 clocks per bit.
// Expected line sequences are hand-computed constants; stop bits are appended per build.
module tb_uart_tx;

    localparam int CPB = 10;
`ifdef UART_TX_TWO_STOP_EN
    localparam int EXTRA_STOP = 1;
`else
    localparam int EXTRA_STOP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] data;
    logic       dvalid;
    logic       pen;
    logic       psel;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .p_clk_speed_hz(1_000_000),
        .p_baud_rate   (100_000)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .enable_i     (enable),
        .data_i       (data),
        .data_valid_i (dvalid),
        .data_ready_o (ready),
        .parity_en_i  (pen),
        .parity_sel_i (psel),
        .tx_o         (tx),
        .busy_o       (busy),
        .done_o       (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the accept edge. pre holds start/data/parity line bits, bit 0 first.
    // mode: 0 plain, 1 scramble inputs after accept, 2 inject a byte while busy,
    //       3 drop enable mid-frame, 4 keep data_valid held high.
    task automatic check_frame(input logic [9:0] pre, input int npre, input int mode,
                               input string name);
        int nbits;
        logic [3:0] act;
        logic [3:0] exp;
        logic bitv;
        nbits = npre + 1 + EXTRA_STOP;
        for (int k = 0; k < nbits * CPB; k++) begin
            bitv = ((k / CPB) < npre) ? pre[k / CPB] : 1'b1;
            act  = {tx, busy, done, ready};
            exp  = {bitv, 1'b1, 1'b0, 1'b0};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL %s k=%0d {tx,busy,done,ready} got=%b want=%b", name, k, act, exp);
            end
            if (mode == 1 && k == 0) begin
                data = ~data;
                pen  = ~pen;
                psel = ~psel;
            end
            if (mode == 2 && k == 30) begin
                data   = 8'h3C;
                dvalid = 1'b1;
            end
            if (mode == 2 && k == 31) dvalid = 1'b0;
            if (mode == 3 && k == 50) enable = 1'b0;
            if (mode == 3 && k == nbits * CPB - 1) enable = 1'b1;
            step();
        end
        act = {tx, busy, done, ready};
        exp = 4'b1011;
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s_done {tx,busy,done,ready} got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic pe, input logic ps,
                        input logic [9:0] pre, input int npre, input int mode,
                        input string name);
        data   = b;
        pen    = pe;
        psel   = ps;
        dvalid = 1'b1;
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready got=%b want=1", name, ready);
        end
        step();
        if (mode != 4) dvalid = 1'b0;
        check_frame(pre, npre, mode, name);
    endtask

    task automatic check_idle(input int cycles, input string name);
        logic [3:0] act;
        for (int i = 0; i < cycles; i++) begin
            step();
            act = {tx, busy, done, ready};
            total++;
            if (act !== {3'b100, enable}) begin
                bad++;
                $display("FAIL %s idle cyc=%0d {tx,busy,done,ready} got=%b want=%b",
                         name, i, act, {3'b100, enable});
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] act;
        rst_n  = 1'b0;
        enable = 1'b1;
        dvalid = 1'b1;
        data   = 8'h55;
        pen    = 1'b0;
        psel   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            act = {tx, busy, done, ready};
            total++;
            if (act !== 4'b1000) begin
                bad++;
                $display("FAIL reset {tx,busy,done,ready} got=%b want=1000", act);
            end
        end
        rst_n  = 1'b1;
        dvalid = 1'b0;
        check_idle(2, "post_reset");
    endtask

    task automatic test_frame_basic();
        send(8'hA5, 1'b0, 1'b0, 10'b01_0100_1010, 9, 1, "a5_noparity");
        check_idle(2, "a5_noparity");
    endtask

    task automatic test_parity();
        send(8'hA5, 1'b1, 1'b1, 10'b01_0100_1010, 10, 0, "a5_par_sel1");
        check_idle(1, "a5_par_sel1");
        send(8'hA5, 1'b1, 1'b0, 10'b11_0100_1010, 10, 3, "a5_par_sel0");
        check_idle(1, "a5_par_sel0");
    endtask

    task automatic test_busy_ignore();
        send(8'hA5, 1'b0, 1'b0, 10'b01_0100_1010, 9, 2, "busy_ignore");
        check_idle(3, "busy_ignore");
    endtask

    task automatic test_enable_block();
        enable = 1'b0;
        dvalid = 1'b1;
        data   = 8'h3C;
        check_idle(4, "enable_low");
        dvalid = 1'b0;
        enable = 1'b1;
        check_idle(1, "enable_high");
    endtask

    task automatic test_back_to_back();
        send(8'h00, 1'b0, 1'b0, 10'b00_0000_0000, 9, 4, "b2b_00");
        send(8'hFF, 1'b0, 1'b0, 10'b01_1111_1110, 9, 0, "b2b_ff");
        check_idle(2, "b2b");
    endtask

    task automatic test_reset_midframe();
        logic [3:0] act;
        data   = 8'hA5;
        pen    = 1'b0;
        psel   = 1'b0;
        dvalid = 1'b1;
        step();
        dvalid = 1'b0;
        repeat (35) step();
        act = {tx, busy};
        total++;
        if (act !== 2'b11) begin
            bad++;
            $display("FAIL midframe_running {tx,busy} got=%b want=11", act);
        end
        rst_n = 1'b0;
        #1;
        act = {tx, busy, done, ready};
        total++;
        if (act !== 4'b1000) begin
            bad++;
            $display("FAIL midframe_reset {tx,busy,done,ready} got=%b want=1000", act);
        end
        step();
        step();
        rst_n = 1'b1;
        check_idle(1, "after_reset");
        send(8'h81, 1'b0, 1'b0, 10'b01_0000_0010, 9, 0, "x81_after_reset");
        check_idle(1, "x81_after_reset");
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_parity();
        test_busy_ignore();
        test_enable_block();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter. Serialises one 8-bit byte per frame onto the tx line: start bit, 8 data bits LSB first, optional parity bit, stop bit. It is the transmit-side counterpart of uart_rx and uses the same parameters, parity controls and frame format, so a uart_tx/uart_rx pair with identical settings forms a loopback link. The host side uses a valid/ready byte handshake.

Parameters:
- p_clk_speed_hz, 50_000_000, input clock frequency in Hz.
- p_baud_rate, 9_600, line bit rate.
- Derived constant CYCLES_PER_BIT = p_clk_speed_hz / p_baud_rate (integer division).
- Counter width = $clog2(CYCLES_PER_BIT)+1.
- Elaboration must fail if CYCLES_PER_BIT < 2.

Ports:
- clk_i  input  1  single clock domain.
- rst_n_i  input  1  reset, asynchronous assertion, active-low.
- enable_i  input  1  permits new frames to be accepted.
- data_i  input  8  byte to send.
- data_valid_i  input  1  data_i is valid.
- data_ready_o  output  1  block can accept a byte this cycle.
- parity_en_i  input  1  append a parity bit.
- parity_sel_i  input  1  parity bit value selector (see Behaviour).
- tx_o  output  1  serial line; idle high.
- busy_o  output  1  frame in progress.
- done_o  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset values while rst_n_i=0: tx_o=1, busy_o=0, done_o=0, data_ready_o=0, state=IDLE, counters=0. Reset takes effect immediately, including mid-frame: tx_o returns high with no partial stop bit.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- data_ready_o = enable_i && state==IDLE (combinational).
- Accept occurs on the edge where data_valid_i && data_ready_o. At accept, latch data_i, parity_en_i and parity_sel_i; later changes to these inputs have no effect on the frame.
- data_valid_i while busy is ignored; nothing is queued.
- tx_o is registered. It drives 0 from the accept edge onward, so the start bit appears 1 cycle after valid&&ready is sampled.
- Bit timing: every bit is held exactly CYCLES_PER_BIT cycles. The cycle counter runs 0..CYCLES_PER_BIT-1, and the bit advances on the terminal count.
- DATA: bit_cnt 0..7 sends data bit bit_cnt, LSB first. After bit 7 the next state is PARITY if the latched parity_en is set, otherwise STOP.
- PARITY bit value = parity_sel ? ^data : ~^data. This matches uart_rx's check.
- STOP: tx_o=1 for CYCLES_PER_BIT cycles. At the terminal count, go to IDLE and pulse done_o for 1 cycle.
- Minimum inter-frame gap is 1 idle cycle: the earliest next accept is the first IDLE cycle after done_o.
- busy_o = state!=IDLE.
- Frame length = (10 + parity) * CYCLES_PER_BIT cycles.
- Deasserting enable_i mid-frame does not abort the frame; it only blocks the next accept.
- Unreachable state encodings recover to IDLE with tx_o=1.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2*CYCLES_PER_BIT cycles, and done_o pulses at the end of the second stop bit.
- Undefined: single stop bit, exactly as described above.
- No port changes either way.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE/START/DATA/PARITY/STOP/ERROR as a 3-bit localparam set shared with uart_rx);
  - a cycles-per-bit function;
  - the parity helper function (sel, byte) -> bit.
- One natural sub-module: uart_baud_cnt. It is a cycle counter with a clear input and a terminal-count pulse, parameterised on CYCLES_PER_BIT, and is reusable by uart_rx.

Test Plan:
(All at p_clk_speed_hz=1_000_000, p_baud_rate=100_000, so CYCLES_PER_BIT=10.)
- Send 0xA5, parity off -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles. busy_o high for 100 cycles. done_o pulses once, 100 cycles after accept.
- Send 0xA5 with parity_en=1 -> sel=1 gives parity bit 0; sel=0 gives parity bit 1. Frame is 110 cycles.
- Pulse data_valid_i with 0x3C while busy -> ignored. Only the first byte is transmitted, and data_ready_o stays 0 until IDLE.
- Hold valid continuously and send 0x00 then 0xFF back-to-back -> second start bit begins 1 cycle after done_o. Loopback into uart_rx gives data_o 0x00 then 0xFF with no parity or framing errors.
- Assert rst_n_i low at cycle 35 of a frame -> tx_o=1 and busy_o=0 immediately. After release, a new byte 0x81 transmits correctly.
- With UART_TX_TWO_STOP_EN defined, send 0xA5 -> stop high for 20 cycles. done_o pulses at cycle 110.
